// File: rtl/pipe_sequencer_pkg.sv
// Shared RV32I pipeline types: stage indices, PC select encoding and the
// helper that builds per-stage masks from the pipeline parameters.
package rv32i_types;

  localparam int MAX_STAGES = 8;

  localparam int IF_STG = 0;
  localparam int ID_STG = 1;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

  // Bits lo..hi set, all others clear.
  function automatic logic [MAX_STAGES-1:0] stage_mask(input int lo, input int hi);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_sequencer.sv
// N-stage stall/flush sequencer: per-stage load/flush enables, PC control,
// redirect-during-fetch handling and saturating performance counters.
//
// pend state | meaning
// PEND_IDLE  | no redirect waiting; PC follows normal stall rules
// PEND_WAIT  | target captured during imem_stall; PC held until fetch returns
module pipe_sequencer
  import rv32i_types::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int MEM_STAGE      = 3,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imem_stall,
  input  logic                  dmem_stall,
  input  logic                  load_use_hazard,
  input  logic                  redirect,
  input  logic                  cnt_clear,
  output logic                  pc_load,
  output logic                  pc_sel,
  output logic                  tgt_load,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam logic [0:0] PEND_IDLE = 1'b0;
  localparam logic [0:0] PEND_WAIT = 1'b1;

  localparam logic [MAX_STAGES-1:0] ALL_W     = stage_mask(ID_STG, NUM_STAGES-1);
  localparam logic [MAX_STAGES-1:0] FRZ_DM_W  = stage_mask(ID_STG, MEM_STAGE);
  localparam logic [MAX_STAGES-1:0] FLS_DM_W  = stage_mask(MEM_STAGE+1, MEM_STAGE+1);
  localparam logic [MAX_STAGES-1:0] FRZ_LU_W  = stage_mask(ID_STG, MEM_STAGE-1);
  localparam logic [MAX_STAGES-1:0] FLS_LU_W  = stage_mask(MEM_STAGE, MEM_STAGE);
  localparam logic [MAX_STAGES-1:0] FLS_IF_W  = stage_mask(ID_STG, ID_STG);
  localparam logic [MAX_STAGES-1:0] FLS_RED_W = stage_mask(ID_STG, REDIRECT_STAGE);

  localparam logic [NUM_STAGES-1:0] ALL_MASK = ALL_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FRZ_DM   = FRZ_DM_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FLS_DM   = FLS_DM_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FRZ_LU   = FRZ_LU_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FLS_LU   = FLS_LU_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FLS_IF   = FLS_IF_W[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] FLS_RED  = FLS_RED_W[NUM_STAGES-1:0];

  logic [0:0]            pend_q, pend_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] frz, fls;
  logic                  fetch_valid;

  always_comb begin
    frz      = '0;
    fls      = '0;
    pc_load  = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    tgt_load = 1'b0;
    pend_d   = pend_q;
    if (!reset_n) begin
      fls = ALL_MASK;
    end else begin
      if (dmem_stall) begin
        frz = FRZ_DM;
        fls = FLS_DM;
      end else if (load_use_hazard) begin
        frz = FRZ_LU;
        fls = FLS_LU;
      end else if (imem_stall) begin
        fls = FLS_IF;
      end
      // A frozen resolve stage keeps its redirect, so it is simply retried later.
      if (redirect && !frz[REDIRECT_STAGE]) begin
        fls = fls | FLS_RED;
        if (imem_stall) begin
          tgt_load = 1'b1;
          pend_d   = PEND_WAIT;
        end else begin
          pc_load = 1'b1;
          pc_sel  = PC_SEL_TGT;
        end
      end else if (pend_q == PEND_WAIT) begin
        if (!imem_stall && (frz == '0)) begin
          pc_load = 1'b1;
          pc_sel  = PC_SEL_TGT;
          fls     = fls | FLS_IF;
          pend_d  = PEND_IDLE;
        end
      end else if (!imem_stall && (frz == '0)) begin
        pc_load = 1'b1;
      end
    end
  end

  assign stage_load  = reset_n ? (ALL_MASK & ~frz) : '0;
  assign stage_flush = fls;
  assign fetch_valid = valid_q[IF_STG] && !imem_stall && (pend_q == PEND_IDLE);

  always_comb begin
    valid_d         = valid_q;
    valid_d[IF_STG] = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (fls[i]) begin
        valid_d[i] = 1'b0;
      end else if (stage_load[i]) begin
        valid_d[i] = (i == ID_STG) ? fetch_valid : valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q  <= PEND_IDLE;
      valid_q <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  assign stage_valid = valid_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (|frz),
    .count  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (|fls),
    .count  (bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .inc    (valid_q[NUM_STAGES-1]),
    .count  (retire_cnt)
  );

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer at default geometry, plus a 4-bit
// counter instance sharing the same stimulus for saturation checks.
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, imem_stall, dmem_stall, load_use_hazard, redirect, cnt_clear;
  logic        pc_load, pc_sel, tgt_load;
  logic [4:0]  stage_load, stage_flush, stage_valid;
  logic [31:0] stall_cnt, bubble_cnt, retire_cnt;

  logic        pc_load4, pc_sel4, tgt_load4;
  logic [4:0]  stage_load4, stage_flush4, stage_valid4;
  logic [3:0]  stall_cnt4, bubble_cnt4, retire_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_sequencer dut (
    .clk(clk), .reset_n(reset_n), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_use_hazard(load_use_hazard), .redirect(redirect), .cnt_clear(cnt_clear),
    .pc_load(pc_load), .pc_sel(pc_sel), .tgt_load(tgt_load),
    .stage_load(stage_load), .stage_flush(stage_flush), .stage_valid(stage_valid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
  );

  pipe_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_use_hazard(load_use_hazard), .redirect(redirect), .cnt_clear(cnt_clear),
    .pc_load(pc_load4), .pc_sel(pc_sel4), .tgt_load(tgt_load4),
    .stage_load(stage_load4), .stage_flush(stage_flush4), .stage_valid(stage_valid4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4), .retire_cnt(retire_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_valid [5];
    exp_valid[0] = 5'b00001; exp_valid[1] = 5'b00011; exp_valid[2] = 5'b00111;
    exp_valid[3] = 5'b01111; exp_valid[4] = 5'b11111;

    reset_n = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    load_use_hazard = 1'b0; redirect = 1'b0; cnt_clear = 1'b0;
    tick(); tick();
    chk("rst_pc_load", pc_load, 0);
    chk("rst_tgt_load", tgt_load, 0);
    chk("rst_stage_load", stage_load, 5'b00000);
    chk("rst_stage_flush", stage_flush, 5'b11110);
    chk("rst_valid", stage_valid, 5'b00000);
    chk("rst_retire", retire_cnt, 0);

    // Free run from reset
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("free_valid_%0d", k + 1), stage_valid, exp_valid[k]);
    end
    chk("free_pc_load", pc_load, 1);
    chk("free_stage_load", stage_load, 5'b11110);
    chk("free_retire5", retire_cnt, 0);
    tick();
    chk("free_retire6", retire_cnt, 1);

    // dmem_stall for 3 cycles
    dmem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("dm_stage_load", stage_load, 5'b10000);
      chk("dm_stage_flush", stage_flush, 5'b10000);
      chk("dm_pc_load", pc_load, 0);
      tick();
    end
    dmem_stall = 1'b0;
    chk("dm_stall_cnt", stall_cnt, 3);
    chk("dm_bubble_cnt", bubble_cnt, 3);
    chk("dm_valid4_low", stage_valid[4], 0);
    chk("dm_retire", retire_cnt, 2);
    tick();
    chk("dm_valid_after", stage_valid, 5'b11111);

    // load-use hazard for 1 cycle
    load_use_hazard = 1'b1;
    #1;
    chk("lu_pc_load", pc_load, 0);
    chk("lu_stage_load", stage_load, 5'b11000);
    chk("lu_stage_flush", stage_flush, 5'b01000);
    tick();
    load_use_hazard = 1'b0;
    chk("lu_valid", stage_valid, 5'b10111);
    chk("lu_stall_cnt", stall_cnt, 4);

    // redirect with fetch available
    redirect = 1'b1;
    #1;
    chk("red_pc_load", pc_load, 1);
    chk("red_pc_sel", pc_sel, 1);
    chk("red_flush", stage_flush, 5'b00110);
    chk("red_tgt_load", tgt_load, 0);
    tick();
    redirect = 1'b0;
    chk("red_valid", stage_valid, 5'b01001);
    chk("red_bubble_cnt", bubble_cnt, 5);

    // redirect during outstanding fetch, stall held 2 more cycles
    redirect = 1'b1; imem_stall = 1'b1;
    #1;
    chk("pend_tgt_load", tgt_load, 1);
    chk("pend_pc_load", pc_load, 0);
    chk("pend_flush", stage_flush, 5'b00110);
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("pend_hold_tgt", tgt_load, 0);
      chk("pend_hold_pc_load", pc_load, 0);
      chk("pend_hold_flush", stage_flush, 5'b00010);
      tick();
    end
    imem_stall = 1'b0;
    #1;
    chk("pend_rel_pc_load", pc_load, 1);
    chk("pend_rel_pc_sel", pc_sel, 1);
    chk("pend_rel_flush", stage_flush, 5'b00010);
    tick();
    chk("pend_after_pc_sel", pc_sel, 0);
    chk("pend_after_pc_load", pc_load, 1);
    chk("pend_after_flush", stage_flush, 5'b00000);
    chk("pend_after_valid1", stage_valid[1], 0);
    chk("pend_bubble_cnt", bubble_cnt, 9);

    // redirect blocked by dmem_stall, taken once it falls
    redirect = 1'b1; dmem_stall = 1'b1;
    #1;
    chk("rdm_pc_sel", pc_sel, 0);
    chk("rdm_pc_load", pc_load, 0);
    chk("rdm_flush", stage_flush, 5'b10000);
    chk("rdm_tgt_load", tgt_load, 0);
    tick();
    dmem_stall = 1'b0;
    #1;
    chk("rdm_rel_pc_load", pc_load, 1);
    chk("rdm_rel_pc_sel", pc_sel, 1);
    chk("rdm_rel_flush", stage_flush, 5'b00110);
    tick();
    redirect = 1'b0;

    // reset while a redirect is pending clears it
    redirect = 1'b1; imem_stall = 1'b1;
    tick();
    redirect = 1'b0; reset_n = 1'b0;
    #1;
    chk("rstp_flush", stage_flush, 5'b11110);
    chk("rstp_pc_load", pc_load, 0);
    tick();
    reset_n = 1'b1; imem_stall = 1'b0;
    #1;
    chk("rstp_pc_sel", pc_sel, 0);
    chk("rstp_pc_load_after", pc_load, 1);
    chk("rstp_retire", retire_cnt, 0);
    chk("rstp_retire4", retire_cnt4, 0);

    // 4-bit retire counter saturation and clear
    for (int k = 0; k < 20; k++) tick();
    chk("sat_retire4_at15", retire_cnt4, 15);
    chk("sat_retire_at15", retire_cnt, 15);
    for (int k = 0; k < 5; k++) tick();
    chk("sat_retire4_held", retire_cnt4, 15);
    chk("sat_retire_20", retire_cnt, 20);
    cnt_clear = 1'b1;
    #1;
    chk("sat_clear_pre", retire_cnt4, 15);
    tick();
    cnt_clear = 1'b0;
    chk("sat_clear_retire4", retire_cnt4, 0);
    chk("sat_clear_retire", retire_cnt, 0);
    tick();
    chk("sat_resume_retire4", retire_cnt4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
